// File: rtl/l1_port_responder.sv
// Local scratchpad standing in for an L1 cache port: fixed-latency in-order reads,
// byte-masked writes, a cap on in-flight reads, and a zero-fill of the array after reset.
//
// state | meaning
// INIT  | zero-filling the array one word per cycle; requests ignored
// RUN   | serving read/write requests until the next reset
module l1_port_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int INDEX_BITS      = 10,
    parameter int LATENCY         = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     read,
    input  logic                                     write,
    input  logic [DATA_WIDTH/8-1:0]                  w_byte_en,
    input  logic [ADDRESS_BITS-1:0]                  address,
    input  logic [DATA_WIDTH-1:0]                    data_in,
    output logic [DATA_WIDTH-1:0]                    data_out,
    output logic [ADDRESS_BITS-1:0]                  out_address,
    output logic                                     valid,
    output logic                                     ready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int NUM_WORDS = 2 ** INDEX_BITS;
    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   clr_ptr;
    logic [INDEX_BITS-1:0]   idx;
    logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   merged;
    logic                    rd_acc;
    logic                    wr_acc;

    logic                    pipe_vld  [LATENCY];
    logic [ADDRESS_BITS-1:0] pipe_addr [LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_data [LATENCY];

    logic                    unused_addr_bits;

    // Low two bits and everything above the index alias onto the same word.
    assign idx              = address[INDEX_BITS+1:2];
    assign unused_addr_bits = ^{address[1:0], address[ADDRESS_BITS-1:INDEX_BITS+2]};

    assign ready  = (state == RUN) && (outstanding < OUT_WIDTH'(MAX_OUTSTANDING));
    assign rd_acc = ready & read;
    assign wr_acc = ready & write;

    // Post-merge word; with no write this is just the current contents, so a plain
    // read sees pre-update data and a read+write sees its own merged result.
    always_comb begin
        merged = mem[idx];
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (write && w_byte_en[k]) begin
                merged[8*k +: 8] = data_in[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= INIT;
            clr_ptr     <= '0;
            outstanding <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            case (state)
                INIT: begin
                    clr_ptr <= clr_ptr + INDEX_BITS'(1);
                    if (clr_ptr == '1) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            if (rd_acc && !valid) begin
                outstanding <= outstanding + OUT_WIDTH'(1);
            end else if (!rd_acc && valid) begin
                outstanding <= outstanding - OUT_WIDTH'(1);
            end

            // Payload registers only load behind a valid entry, so the last stage
            // holds the previous response while valid is low.
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_addr[0] <= address;
                pipe_data[0] <= merged;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_addr[i] <= pipe_addr[i-1];
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign valid       = pipe_vld[LATENCY-1];
    assign data_out    = pipe_data[LATENCY-1];
    assign out_address = pipe_addr[LATENCY-1];

endmodule

// File: tb/tb_l1_port_responder.sv
// Bench for l1_port_responder: directed scenarios plus random traffic checked
// against a cycle-level model built from an array and a queue of pending responses.
module tb_l1_port_responder;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int IB  = 4;
    localparam int LAT = 3;
    localparam int MO  = 2;
    localparam int OW  = $clog2(MO + 1);
    localparam int NW  = 1 << IB;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [3:0]    w_byte_en = '0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [AW-1:0] out_address;
    logic          valid;
    logic          ready;
    logic [OW-1:0] outstanding;

    l1_port_responder #(
        .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .INDEX_BITS(IB),
        .LATENCY(LAT), .MAX_OUTSTANDING(MO)
    ) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .w_byte_en(w_byte_en), .address(address), .data_in(data_in),
        .data_out(data_out), .out_address(out_address), .valid(valid),
        .ready(ready), .outstanding(outstanding)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } resp_t;

    logic [DW-1:0] mmem [NW];
    resp_t         q [$];
    int            edge_n = 0;
    int            init_left = 0;
    bit            m_ready = 1'b0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [AW-1:0] m_addr = '0;
    bit            acc_rd = 1'b0;

    function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                                 input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < DW/8; k++) if (be[k]) r[8*k +: 8] = din[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NW; i++) mmem[i] = '0;
        init_left = NW;
        m_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_addr    = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the rising edge, return at negedge.
    task automatic tick(input bit rd, input bit wr, input logic [3:0] be,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        int            w;
        logic [DW-1:0] nw;
        bit            acc_any;
        read = rd; write = wr; w_byte_en = be; address = a; data_in = d;
        @(posedge clock);
        edge_n++;
        acc_any = m_ready && (rd || wr);
        acc_rd  = m_ready && rd;
        if (m_valid) void'(q.pop_front());
        if (acc_any) begin
            w  = int'(a[IB+1:2]);
            nw = wr ? merge_word(mmem[w], d, be) : mmem[w];
            if (rd) q.push_back('{edge_n + LAT - 1, nw, a});
            mmem[w] = nw;
        end
        if (init_left > 0) init_left--;
        m_valid = (q.size() > 0) && (q[0].due == edge_n);
        if (m_valid) begin
            m_data = q[0].data;
            m_addr = q[0].addr;
        end
        m_ready = (init_left == 0) && (q.size() < MO);
        @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) tick(1'b0, 1'b0, 4'h0, '0, '0);
    endtask

    task automatic test_reset();
        int ready_low;
        int acc_e;
        int lat;
        bit got;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({valid, ready, outstanding, data_out, out_address} !== '0) begin
            bad++;
            $display("FAIL reset_state: got vld=%b rdy=%b out=%0d dout=%h oaddr=%h want all zero",
                     valid, ready, outstanding, data_out, out_address);
        end
        reset = 1'b1;
        model_reset();
        ready_low = (ready === 1'b0) ? 1 : 0;
        for (int i = 0; i < NW + 2; i++) begin
            tick(1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF);
            if (i == NW - 1) begin
                read = 1'b0; write = 1'b0;
            end
            total++;
            if ({valid, ready, outstanding} !== {m_valid, m_ready, OW'(q.size())}) begin
                bad++;
                $display("FAIL init_cycle %0d: vld/rdy/out got %b/%b/%0d want %b/%b/%0d",
                         i, valid, ready, outstanding, m_valid, m_ready, q.size());
            end
            if (ready === 1'b0) ready_low++;
            if (i == NW - 2) break;
        end
        tick(1'b0, 1'b0, 4'h0, '0, '0);
        if (ready === 1'b0) ready_low++;
        total++;
        if (ready_low != NW || ready !== 1'b1) begin
            bad++;
            $display("FAIL init_length: ready low for %0d cycles, ready now %b, want %0d and 1",
                     ready_low, ready, NW);
        end
        tick(1'b1, 1'b0, 4'h0, 32'h0000_0020, '0);
        acc_e = edge_n;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1'b0, 1'b0, 4'h0, '0, '0);
            if (valid === 1'b1) begin
                got = 1'b1;
                lat = edge_n - acc_e + 1;
            end
        end
        total++;
        if (!got || lat != LAT || data_out !== 32'h0 || out_address !== 32'h20) begin
            bad++;
            $display("FAIL first_read: got=%b lat=%0d dout=%h oaddr=%h want lat=%0d dout=0 oaddr=20",
                     got, lat, data_out, out_address, LAT);
        end
    endtask

    task automatic test_byte_write();
        bit got;
        drain();
        tick(1'b0, 1'b1, 4'hF, 32'h08, 32'hDEAD_BEEF);
        tick(1'b0, 1'b1, 4'h1, 32'h08, 32'h0000_0011);
        tick(1'b0, 1'b1, 4'h0, 32'h08, 32'hFFFF_FFFF);
        total++;
        if (valid !== 1'b0 || outstanding !== '0) begin
            bad++;
            $display("FAIL write_no_resp: vld=%b out=%0d want 0/0", valid, outstanding);
        end
        tick(1'b1, 1'b0, 4'h0, 32'h08, '0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1'b0, 1'b0, 4'h0, '0, '0);
            if (valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || data_out !== 32'hDEAD_BE11 || out_address !== 32'h08) begin
            bad++;
            $display("FAIL byte_write: got=%b dout=%h oaddr=%h want deadbe11 @08", got, data_out, out_address);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0]   acc_mask;
        logic [15:0]   val_mask;
        logic [AW-1:0] a;
        int            max_o;
        drain();
        acc_mask = '0;
        val_mask = '0;
        max_o = 0;
        for (int c = 0; c < 13; c++) begin
            if (ready === 1'b1) acc_mask[c] = 1'b1;
            a = $urandom();
            tick(1'b1, 1'b0, 4'h0, a, '0);
            total++;
            if ({valid, ready, outstanding, data_out, out_address} !==
                {m_valid, m_ready, OW'(q.size()), m_data, m_addr}) begin
                bad++;
                $display("FAIL b2b_cycle %0d: vld/rdy/out/dout got %b/%b/%0d/%h want %b/%b/%0d/%h",
                         c, valid, ready, outstanding, data_out, m_valid, m_ready, q.size(), m_data);
            end
            if (valid === 1'b1) val_mask[c+1] = 1'b1;
            if (int'(outstanding) > max_o) max_o = int'(outstanding);
        end
        total++;
        if (acc_mask !== 16'h1333 || val_mask !== 16'h1998 || max_o != MO) begin
            bad++;
            $display("FAIL back_to_back: acc=%h val=%h max_out=%0d want acc=1333 val=1998 max_out=%0d",
                     acc_mask, val_mask, max_o, MO);
        end
    endtask

    task automatic test_read_write_merge();
        bit got;
        drain();
        tick(1'b0, 1'b1, 4'hF, 32'h10, 32'hAAAA_AAAA);
        tick(1'b1, 1'b1, 4'b1100, 32'h10, 32'h1234_5678);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1'b0, 1'b0, 4'h0, '0, '0);
            if (valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || data_out !== 32'h1234_AAAA || out_address !== 32'h10) begin
            bad++;
            $display("FAIL rw_merge: got=%b dout=%h oaddr=%h want 1234aaaa @10", got, data_out, out_address);
        end
        tick(1'b1, 1'b0, 4'h0, 32'h10, '0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1'b0, 1'b0, 4'h0, '0, '0);
            if (valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || data_out !== 32'h1234_AAAA) begin
            bad++;
            $display("FAIL rw_readback: got=%b dout=%h want 1234aaaa", got, data_out);
        end
    endtask

    task automatic test_alias();
        bit got;
        drain();
        tick(1'b0, 1'b1, 4'hF, 32'h04, 32'h0000_0055);
        tick(1'b1, 1'b0, 4'h0, 32'h44, '0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1'b0, 1'b0, 4'h0, '0, '0);
            if (valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || data_out !== 32'h0000_0055 || out_address !== 32'h44) begin
            bad++;
            $display("FAIL alias: got=%b dout=%h oaddr=%h want 00000055 @44", got, data_out, out_address);
        end
    endtask

    task automatic test_random();
        bit            rd;
        bit            wr;
        logic [3:0]    be;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        drain();
        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 2) != 0);
            wr = ($urandom_range(0, 1) != 0);
            be = 4'($urandom());
            a  = $urandom();
            d  = $urandom();
            tick(rd, wr, be, a, d);
            total++;
            if ({valid, ready, outstanding} !== {m_valid, m_ready, OW'(q.size())}) begin
                bad++;
                $display("FAIL rand_ctrl %0d: vld/rdy/out got %b/%b/%0d want %b/%b/%0d",
                         i, valid, ready, outstanding, m_valid, m_ready, q.size());
            end
            total++;
            if ({data_out, out_address} !== {m_data, m_addr}) begin
                bad++;
                $display("FAIL rand_data %0d: dout/oaddr got %h/%h want %h/%h",
                         i, data_out, out_address, m_data, m_addr);
            end
        end
    endtask

    task automatic test_reset_midop();
        int vcount;
        bit both;
        bit got;
        drain();
        tick(1'b0, 1'b1, 4'hF, 32'h0C, 32'h0000_0077);
        tick(1'b1, 1'b0, 4'h0, 32'h0C, '0);
        both = acc_rd;
        tick(1'b1, 1'b0, 4'h0, 32'h18, '0);
        both = both && acc_rd;
        total++;
        if (!both || outstanding !== OW'(2)) begin
            bad++;
            $display("FAIL midop_setup: accepted both=%b out=%0d want 1/2", both, outstanding);
        end
        read = 1'b0; write = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({valid, ready, outstanding} !== '0) begin
            bad++;
            $display("FAIL midop_async: vld/rdy/out got %b/%b/%0d want 0/0/0", valid, ready, outstanding);
        end
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        vcount = 0;
        for (int i = 0; i < NW + LAT + 2; i++) begin
            tick(1'b0, 1'b0, 4'h0, '0, '0);
            if (valid === 1'b1) vcount++;
            total++;
            if ({ready, outstanding} !== {m_ready, OW'(q.size())}) begin
                bad++;
                $display("FAIL midop_init %0d: rdy/out got %b/%0d want %b/%0d",
                         i, ready, outstanding, m_ready, q.size());
            end
        end
        total++;
        if (vcount != 0) begin
            bad++;
            $display("FAIL midop_no_valid: saw %0d valids want 0", vcount);
        end
        tick(1'b1, 1'b0, 4'h0, 32'h0C, '0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1'b0, 1'b0, 4'h0, '0, '0);
            if (valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || data_out !== 32'h0 || out_address !== 32'h0C) begin
            bad++;
            $display("FAIL midop_cleared: got=%b dout=%h oaddr=%h want 0 @0c", got, data_out, out_address);
        end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_back_to_back();
        test_read_write_merge();
        test_alias();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
